ratio_frontend: RTL and testbench
=================================

# ratio_frontend

Upstream sequencer for the reciprocal/ratio divider in the lock loop. It block-averages two ADC channels over 2^AVG_LOG2 samples and issues one divider operation per batch: signed error average as numerator, unsigned power average as denominator. It waits for the divider to complete and re-publishes the quotient as a single-cycle-valid result for the PI stage. Accumulation continues while the divider is busy.

## Interface
- AVG_LOG2, 4, log2 of samples per batch; range 0..8
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- sample_valid  in  1  ch0/ch1 sampled on this cycle
- ch0  in  16  signed two's-complement numerator sample
- ch1  in  16  unsigned denominator sample
- mode  in  4  shift code forwarded to divider; 0 = pass numerator, F = pass denominator, else divide
- div_once  out  1  one-cycle start pulse to divider
- div_in0  out  16  averaged ch0, held from issue until done
- div_in1  out  16  averaged ch1, held from issue until done
- div_shift  out  4  mode latched at issue
- div_done  in  1  divider completion pulse; div_out valid this cycle
- div_out  in  16  divider result
- res_valid  out  1  one-cycle result strobe
- res  out  16  result, held until next res_valid
- busy  out  1  operation in flight (ISSUE or WAIT)
- overrun  out  1  sticky: a batch completed while busy; cleared only by rst

## Operation
- Accumulators: acc0 signed, acc1 unsigned, 16+AVG_LOG2 bits; sample counter AVG_LOG2 bits.
- On each sample_valid, accumulate and increment the counter. The sample that wraps the counter completes the batch.
- On batch completion, the next cycle holds:
  - avg0 = acc0 >>> AVG_LOG2 (arithmetic, floor)
  - avg1 = acc1 >> AVG_LOG2
  - Both accumulators restart from zero. A sample arriving on the completion cycle counts toward that completing batch, not the next one.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE on batch completion: latch div_in0/div_in1/div_shift.
  - ISSUE: assert div_once for exactly one cycle; go to WAIT.
  - WAIT: on div_done, capture div_out into res and pulse res_valid next cycle; go to IDLE.
- A batch completing in ISSUE or WAIT is discarded and sets overrun. Accumulation restarts normally.
- A batch completing on the same cycle div_done is sampled is also discarded (FSM not yet IDLE).
- div_done outside WAIT is ignored.
- Divider latency is variable (nominally 8 cycles for divide, shorter for pass-through). There is no timeout.

## Timing
- Reset values: div_once 0, div_in0/div_in1 0, div_shift 0, res_valid 0, res 0, busy 0, overrun 0; FSM IDLE; accumulators and counter 0.
- Final sample edge E. Averages latched at E+1; div_once high during E+1..E+2 (one cycle, registered). busy high from E+1 until the edge after div_done.
- div_done high at cycle D: res/res_valid updated at D+1; res_valid low at D+2.
- rst mid-operation: everything returns to reset values immediately. A div_done arriving after rst deasserts is ignored (IDLE).

## Configuration
- RATIO_FE_ZERO_GUARD_EN defined: if avg1 == 0 at batch completion, no divider operation is issued.
  - res is 16'h7FFF when avg0 >= 0, else 16'h8001.
  - res_valid fires at E+2, and busy stays 0.
  - Applies only when mode is not 0 and not F.
- Undefined: zero denominator is issued to the divider like any other value.

## Structure
- Package ratio_fe_pkg: FSM state enum (IDLE, ISSUE, WAIT), SAT_POS = 16'h7FFF, SAT_NEG = 16'h8001, MODE_PASS_NUM = 4'h0, MODE_PASS_DEN = 4'hF.
- One sub-module, ratio_fe_accum: dual-channel accumulator, counter, and average latch with a batch-done pulse. Parameterized by AVG_LOG2.

## Test plan
- AVG_LOG2=2, four samples ch0=100, ch1=200, mode=0; divider model echoes in0 after 8 cycles -> div_in0=100, div_in1=200, div_shift=0, one div_once; res=100 with one res_valid.
- ch0 = -3,-3,-3,-2 (sum -11) -> div_in0 = 16'hFFFD (-3, floor); ch1 = 65535 x4 -> div_in1 = 65535 with no overflow.
- Divider held off 20 cycles while samples stream every cycle (AVG_LOG2=2) -> overrun=1, exactly one div_once and one res_valid for that window, next batch issued normally.
- ZERO_GUARD_EN, ch1=0, ch0=-5, mode=3 -> no div_once; res=16'h8001 at E+2; busy stays 0.
- rst pulse during WAIT, then a stray div_done -> all outputs at reset values; no res_valid; next batch issues cleanly.
- div_done and batch completion on the same cycle -> result captured, new batch discarded, overrun=1.

Source files
------------

// File: rtl/ratio_fe_pkg.sv
// Purpose: shared FSM state type and constants for the ratio divider front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ratio_fe_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } fe_state_t;

   // Saturated results returned when the zero-denominator guard answers locally.
   localparam logic [15:0] SAT_POS = 16'h7FFF;
   localparam logic [15:0] SAT_NEG = 16'h8001;

   // Divider shift codes that bypass the actual division.
   localparam logic [3:0] MODE_PASS_NUM = 4'h0;
   localparam logic [3:0] MODE_PASS_DEN = 4'hF;

endpackage

// File: rtl/ratio_fe_accum.sv
// Purpose: block-average two ADC channels (signed ch0, unsigned ch1) over 2^AVG_LOG2 samples.
// Latency: batch_done is combinational on the wrapping sample; avg0/avg1 valid the cycle after.
// Backpressure: none; every valid sample is absorbed, averages are overwritten on each batch.
module ratio_fe_accum #(
   parameter int AVG_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample_valid,
   input  logic [15:0] ch0,
   input  logic [15:0] ch1,
   output logic        batch_done,
   output logic [15:0] avg0,
   output logic [15:0] avg1
);

   localparam int AW = 16 + AVG_LOG2;
   // Keep the counter at least one bit wide so AVG_LOG2 = 0 (no averaging) still elaborates.
   localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

   logic signed [AW-1:0] acc0;
   logic signed [AW-1:0] sum0;
   logic        [AW-1:0] acc1;
   logic        [AW-1:0] sum1;
   logic        [CW-1:0] cnt;

   // Running sums including the current sample, so the wrapping sample lands in its own batch.
   always_comb begin
      sum0 = acc0 + AW'($signed(ch0));
      sum1 = acc1 + AW'(ch1);
   end

   assign batch_done = sample_valid && (cnt == CNT_LAST);

   // Accumulate each sample; on the wrapping sample publish floor averages and restart from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc0 <= '0;
         acc1 <= '0;
         cnt  <= '0;
         avg0 <= '0;
         avg1 <= '0;
      end else if (sample_valid) begin
         if (batch_done) begin
            acc0 <= '0;
            acc1 <= '0;
            cnt  <= '0;
            avg0 <= 16'(sum0 >>> AVG_LOG2);
            avg1 <= 16'(sum1 >> AVG_LOG2);
         end else begin
            acc0 <= sum0;
            acc1 <= sum1;
            cnt  <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ratio_frontend.sv
// Purpose: sequence one divider operation per averaged batch and republish the quotient as a 1-cycle strobe.
// Latency: div_once 1 cycle after the final sample edge; res_valid 1 cycle after div_done.
// Backpressure: none; batches completing while an operation is in flight are dropped and flag sticky overrun.
// Option RATIO_FE_ZERO_GUARD_EN: a zero average denominator (divide modes only) is answered with a
// saturated result two cycles after the final sample, without starting the divider.
module ratio_frontend
   import ratio_fe_pkg::*;
#(
   parameter int AVG_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample_valid,
   input  logic [15:0] ch0,
   input  logic [15:0] ch1,
   input  logic [3:0]  mode,
   output logic        div_once,
   output logic [15:0] div_in0,
   output logic [15:0] div_in1,
   output logic [3:0]  div_shift,
   input  logic        div_done,
   input  logic [15:0] div_out,
   output logic        res_valid,
   output logic [15:0] res,
   output logic        busy,
   output logic        overrun
);

   fe_state_t   state;
   fe_state_t   state_nxt;
   logic        batch_done;
   logic [15:0] avg0;
   logic [15:0] avg1;
   logic        take;
   logic        issue_go;
   logic        guard_go;
   logic        capture;
   logic        guard_hit;
   logic        guard_pend;
   logic [15:0] guard_res;

   ratio_fe_accum #(
      .AVG_LOG2     (AVG_LOG2)
   ) u_accum (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .ch0          (ch0),
      .ch1          (ch1),
      .batch_done   (batch_done),
      .avg0         (avg0),
      .avg1         (avg1)
   );

`ifdef RATIO_FE_ZERO_GUARD_EN
   assign guard_hit = (avg1 == 16'd0) && (mode != MODE_PASS_NUM) && (mode != MODE_PASS_DEN);
`else
   assign guard_hit = 1'b0;
`endif

   assign busy = (state != IDLE);

   // Accept a batch only if the FSM is idle when it completes; anything else is an overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         take    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         take <= batch_done && (state == IDLE) && !take;
         if (batch_done && ((state != IDLE) || take)) begin
            overrun <= 1'b1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: accepted batch -> one-cycle issue -> wait for the divider's done pulse.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (issue_go) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (div_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM decodes: start divider, answer locally via guard, or capture a result (done ignored outside WAIT).
   always_comb begin
      issue_go = 1'b0;
      guard_go = 1'b0;
      capture  = 1'b0;
      case (state)
         IDLE: begin
            issue_go = take && !guard_hit;
            guard_go = take && guard_hit;
         end
         WAIT:    capture = div_done;
         default: ;
      endcase
   end

   // Registered divider operands, start pulse, and published result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_once   <= 1'b0;
         div_in0    <= '0;
         div_in1    <= '0;
         div_shift  <= '0;
         res_valid  <= 1'b0;
         res        <= '0;
         guard_pend <= 1'b0;
         guard_res  <= '0;
      end else begin
         div_once <= issue_go;
         if (issue_go) begin
            div_in0   <= avg0;
            div_in1   <= avg1;
            div_shift <= mode;
         end
         guard_pend <= guard_go;
         if (guard_go) begin
            guard_res <= avg0[15] ? SAT_NEG : SAT_POS;
         end
         res_valid <= capture || guard_pend;
         if (capture) begin
            res <= div_out;
         end else if (guard_pend) begin
            res <= guard_res;
         end
      end
   end

endmodule

// File: tb/tb_ratio_frontend.sv
// Directed bench for ratio_frontend with AVG_LOG2 = 2; the divider is driven by hand.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Zero-denominator expectations follow RATIO_FE_ZERO_GUARD_EN when it is defined.
`timescale 1ns/1ps
module tb_ratio_frontend;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sample_valid = 1'b0;
   logic [15:0] ch0 = '0;
   logic [15:0] ch1 = '0;
   logic [3:0]  mode = '0;
   logic        div_done = 1'b0;
   logic [15:0] div_out = '0;
   logic        div_once;
   logic [15:0] div_in0;
   logic [15:0] div_in1;
   logic [3:0]  div_shift;
   logic        res_valid;
   logic [15:0] res;
   logic        busy;
   logic        overrun;

   int errors = 0;
   int checks = 0;
   int once_cnt = 0;
   int rv_cnt = 0;
   int o0;
   int r0;

   ratio_frontend #(.AVG_LOG2(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .ch0          (ch0),
      .ch1          (ch1),
      .mode         (mode),
      .div_once     (div_once),
      .div_in0      (div_in0),
      .div_in1      (div_in1),
      .div_shift    (div_shift),
      .div_done     (div_done),
      .div_out      (div_out),
      .res_valid    (res_valid),
      .res          (res),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   // Pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (div_once) once_cnt++;
      if (res_valid) rv_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] b);
      sample_valid = 1'b1;
      ch0 = a;
      ch1 = b;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic finish_div(input logic [15:0] val, input int lat);
      repeat (lat) tick();
      div_done = 1'b1;
      div_out  = val;
      tick();
      div_done = 1'b0;
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      repeat (2) tick();
      check("rst_div_once", div_once, 0);
      check("rst_div_in0", div_in0, 0);
      check("rst_div_in1", div_in1, 0);
      check("rst_div_shift", div_shift, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res", res, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      rst = 1'b0;
      tick();

      // Basic pass-numerator batch: 4 x (100, 200)
      mode = 4'h0;
      o0 = once_cnt;
      r0 = rv_cnt;
      repeat (4) send(16'd100, 16'd200);
      check("t1_busy_at_E", busy, 0);
      check("t1_once_at_E", div_once, 0);
      tick();
      check("t1_once_E1", div_once, 1);
      check("t1_busy_E1", busy, 1);
      check("t1_in0", div_in0, 100);
      check("t1_in1", div_in1, 200);
      check("t1_shift", div_shift, 0);
      tick();
      check("t1_once_E2", div_once, 0);
      check("t1_busy_E2", busy, 1);
      finish_div(16'd100, 6);
      check("t1_res_valid", res_valid, 1);
      check("t1_res", res, 100);
      check("t1_busy_after", busy, 0);
      tick();
      check("t1_res_valid_low", res_valid, 0);
      check("t1_res_held", res, 100);
      check("t1_once_count", once_cnt - o0, 1);
      check("t1_rv_count", rv_cnt - r0, 1);

      // Negative floor average and full-scale denominator
      mode = 4'h5;
      repeat (3) send(16'hFFFD, 16'hFFFF);
      send(16'hFFFE, 16'hFFFF);
      tick();
      check("t2_in0_floor", div_in0, 16'hFFFD);
      check("t2_in1_full", div_in1, 16'hFFFF);
      check("t2_shift", div_shift, 5);
      finish_div(16'h1234, 8);
      check("t2_res", res, 16'h1234);
      check("t2_res_valid", res_valid, 1);
      tick();

      // Divider held off while samples stream: only the first batch issues
      check("t3_overrun_before", overrun, 0);
      mode = 4'h2;
      o0 = once_cnt;
      r0 = rv_cnt;
      repeat (24) send(16'd8, 16'd16);
      check("t3_overrun", overrun, 1);
      check("t3_busy", busy, 1);
      check("t3_in0_kept", div_in0, 8);
      check("t3_in1_kept", div_in1, 16);
      check("t3_once_count", once_cnt - o0, 1);
      finish_div(16'h0AAA, 2);
      check("t3_res", res, 16'h0AAA);
      check("t3_res_valid", res_valid, 1);
      tick();
      check("t3_rv_count", rv_cnt - r0, 1);
      repeat (4) send(16'd40, 16'd80);
      tick();
      check("t3_next_once", div_once, 1);
      check("t3_next_in0", div_in0, 40);
      check("t3_next_in1", div_in1, 80);
      finish_div(16'h0BBB, 3);
      check("t3_next_res", res, 16'h0BBB);
      tick();
      check("t3_overrun_sticky", overrun, 1);

      // Zero denominator in a divide mode
      mode = 4'h3;
      o0 = once_cnt;
      repeat (4) send(16'hFFFB, 16'd0);
`ifdef RATIO_FE_ZERO_GUARD_EN
      tick();
      check("t4_no_once", div_once, 0);
      check("t4_busy_E1", busy, 0);
      check("t4_rv_E1", res_valid, 0);
      tick();
      check("t4_rv_E2", res_valid, 1);
      check("t4_res_sat", res, 16'h8001);
      check("t4_busy_E2", busy, 0);
      tick();
      check("t4_rv_low", res_valid, 0);
      check("t4_once_count", once_cnt - o0, 0);
`else
      tick();
      check("t4_once", div_once, 1);
      check("t4_in0", div_in0, 16'hFFFB);
      check("t4_in1_zero", div_in1, 0);
      check("t4_shift", div_shift, 3);
      finish_div(16'h0007, 4);
      check("t4_res", res, 16'h0007);
      tick();
      check("t4_once_count", once_cnt - o0, 1);
`endif

      // Reset during WAIT, then a stray done
      mode = 4'h0;
      repeat (4) send(16'd7, 16'd9);
      tick();
      tick();
      tick();
      check("t5_busy_wait", busy, 1);
      rst = 1'b1;
      #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_in0", div_in0, 0);
      check("t5_rst_in1", div_in1, 0);
      check("t5_rst_res", res, 0);
      check("t5_rst_overrun", overrun, 0);
      check("t5_rst_once", div_once, 0);
      tick();
      rst = 1'b0;
      r0 = rv_cnt;
      tick();
      div_done = 1'b1;
      div_out  = 16'hDEAD;
      tick();
      div_done = 1'b0;
      check("t5_stray_rv", res_valid, 0);
      check("t5_stray_res", res, 0);
      check("t5_stray_busy", busy, 0);
      tick();
      check("t5_rv_count", rv_cnt - r0, 0);
      repeat (4) send(16'd12, 16'd24);
      tick();
      check("t5_next_once", div_once, 1);
      check("t5_next_in0", div_in0, 12);
      check("t5_next_in1", div_in1, 24);
      finish_div(16'h00CC, 5);
      check("t5_next_res", res, 16'h00CC);
      tick();

      // div_done and batch completion on the same edge
      check("t6_overrun_before", overrun, 0);
      o0 = once_cnt;
      repeat (4) send(16'd1, 16'd2);
      tick();
      tick();
      repeat (3) send(16'd50, 16'd60);
      sample_valid = 1'b1;
      ch0 = 16'd50;
      ch1 = 16'd60;
      div_done = 1'b1;
      div_out  = 16'h5555;
      tick();
      sample_valid = 1'b0;
      div_done = 1'b0;
      check("t6_rv", res_valid, 1);
      check("t6_res", res, 16'h5555);
      check("t6_busy", busy, 0);
      check("t6_overrun", overrun, 1);
      tick();
      check("t6_no_once", div_once, 0);
      check("t6_busy_after", busy, 0);
      tick();
      check("t6_in0_kept", div_in0, 1);
      check("t6_once_count", once_cnt - o0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
